load_align_unit: RTL
====================

// Module: load_align_unit
// PURPOSE
//  Load-path sequencer and formatter for the MA stage: takes one load request (byte addr, length,
//  signedness), issues one or two word-aligned bus reads, merges/shifts the bytes and returns a
//  zero- or sign-extended result. Replaces the stall-driven two-cycle merge with an explicit
//  handshake FSM; generalised to XLEN=32/64 and 1/2/4/8-byte accesses.
// PARAMETERS
//  XLEN  32  data width (32 or 64); BYTES=XLEN/8, OFS_W=log2(BYTES) are localparams
//  AW    32  byte-address width
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous active-high reset
//  req_valid     in   1      load request present
//  req_ready     out  1      unit idle, request accepted when req_valid&&req_ready
//  req_addr      in   AW     byte address
//  req_len       in   2      `MA_LEN_1B/2B/4B, `MA_LEN_8B (2'b11, added to define.vh)
//  req_uns       in   1      1=zero-extend, 0=sign-extend
//  mem_req       out  1      bus read request, held until mem_ack
//  mem_addr      out  AW     word-aligned read address (low OFS_W bits 0)
//  mem_ack       in   1      read data valid this cycle
//  mem_rdata     in   XLEN   read data, little-endian
//  rsp_valid     out  1      one-cycle result strobe
//  rsp_data      out  XLEN   formatted load result
//  rsp_split     out  1      result required two bus reads
//  rsp_err       out  1      illegal length or trapped misalignment
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1, mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0,
//    rsp_split=0, rsp_err=0; lo/hi capture registers cleared.
//  - On accept latch addr, len, uns; ofs=addr[OFS_W-1:0]; n=1/2/4/8; split=(ofs+n>BYTES).
//  - Illegal: `MA_LEN_8B with XLEN=32 -> no bus access, go RESP with rsp_err=1, rsp_data=0.
//  - FSM IDLE->RD0 (accept) ; RD0: mem_req=1, mem_addr={addr[AW-1:OFS_W],0};
//    on mem_ack lo<=mem_rdata, ->RD1 if split else RESP ; RD1: mem_req=1,
//    mem_addr=RD0 addr+BYTES (mod 2^AW, wraps to 0); on mem_ack hi<=mem_rdata ->RESP ;
//    RESP: rsp_valid=1 for exactly one cycle -> IDLE.
//  - req_ready=1 only in IDLE; requests in other states ignored (not queued).
//  - mem_req and mem_addr stable from assertion until the mem_ack cycle; mem_req drops the cycle
//    after ack unless entering RD1 (then stays high, address advances).
//  - Data: shifted={hi,lo}>>(ofs*8) (hi=0 if !split); take low n bytes; bit n*8-1 is sign;
//    uns -> zero-extend; 8B (XLEN=64) and 4B on XLEN=32 pass through; 4B on XLEN=64 extends.
//  - Latency with zero-wait ack: accept cycle T, RD0 T+1, rsp_valid T+2 (split: T+3).
//    Each wait-state cycle on mem_ack adds one cycle.
//  - rsp_data/rsp_split/rsp_err registered, valid only while rsp_valid; hold last value else.
//  - Reset mid-operation (any state): immediate return to reset values next edge; an
//    outstanding bus read is abandoned, late mem_ack in IDLE is ignored.
//  - mem_ack while mem_req=0 has no effect.
// CONFIGURATION
//  LAU_MISALIGN_TRAP_EN defined: split requests perform no bus access; RESP with rsp_err=1,
//    rsp_split=1, rsp_data=0 on T+1. Non-split behaviour unchanged.
//  Not defined: split requests serviced with two reads as above, rsp_err=0.
// TESTING
//  1 XLEN=32 lb addr 0x2001, uns=0, word@0x2000=0x0000_8000 -> one read 0x2000,
//    rsp_data=0xFFFF_FF80, rsp_split=0; same with uns=1 -> 0x0000_0080.
//  2 XLEN=32 lh addr 0x1003 signed, @0x1000=0xAB00_0000, @0x1004=0x0000_00CD -> reads 0x1000
//    then 0x1004, rsp_data=0xFFFF_CDAB, rsp_split=1, rsp_valid at T+3 with zero-wait ack.
//  3 XLEN=32 lw addr 0xFFFF_FFFE, 2 ack wait states per read -> mem_addr 0xFFFF_FFFC then
//    0x0000_0000, mem_req/addr stable during waits, rsp_valid at T+7.
//  4 XLEN=64 ld addr 0x13, uns=0 -> reads 0x10, 0x18, rsp_data = bytes 0x13..0x1A little-
//    endian; lw signed addr 0x14 data 0x8000_0000 in upper word -> 0xFFFF_FFFF_8000_0000.
//  5 rst asserted in RD1 of a split load -> next cycle IDLE, mem_req=0, no rsp_valid;
//    stray mem_ack afterwards ignored; following lb completes normally.
//  6 LAU_MISALIGN_TRAP_EN: lh addr 0x1003 -> no mem_req, rsp_err=1, rsp_split=1 at T+1;
//    XLEN=32 req_len=`MA_LEN_8B -> rsp_err=1 in both builds.

Source files
------------

// File: rtl/load_align_unit_if.sv
// Load/bus/response signal bundle for load_align_unit.
// slave  : the load unit's view (takes requests, drives bus reads, returns results).
// master : the environment's view (issues requests, answers bus reads).
interface load_align_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [1:0]      req_len;
  logic            req_uns;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_split;
  logic            rsp_err;

  modport slave (
    input  req_valid, req_addr, req_len, req_uns, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_split, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_len, req_uns, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_split, rsp_err
  );
endinterface

// File: rtl/load_align_unit.sv
// Load-path sequencer/formatter: accepts one load (addr, len, signedness), issues
// one or two word-aligned bus reads, merges and shifts the bytes and returns a
// zero- or sign-extended result.
// Length encoding on req_len: 00=1B, 01=2B, 10=4B, 11=8B (8B illegal for XLEN=32).
// Optional build macro LAU_MISALIGN_TRAP_EN: loads that straddle a word boundary
// are not serviced; they respond immediately with rsp_err=1, rsp_split=1.
module load_align_unit #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  load_align_unit_if.slave   bus_io
);
  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam logic [1:0] LEN_8B = 2'b11;
`ifdef LAU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RD0, ST_RD1, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic [OFS_W-1:0]  ofs_q;
  logic [1:0]        len_q;
  logic              uns_q;
  logic              split_q;
  logic [AW-1:0]     mem_addr_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_split_q;
  logic              rsp_err_q;

  logic [OFS_W-1:0]  req_ofs;
  logic              req_split;
  logic              req_illegal;
  logic              req_trap;
  logic              req_ready_c, mem_req_c, rsp_valid_c;

  // Shift the two-word window down to the byte offset, keep n bytes and extend
  // from bit n*8-1 (or with zeros when unsigned).
  function automatic logic [XLEN-1:0] fmt_load(input logic [2*XLEN-1:0] win,
                                                input logic [OFS_W-1:0]  ofs,
                                                input logic [1:0]        len,
                                                input logic              uns);
    logic [2*XLEN-1:0] sh;
    logic              sgn;
    logic [XLEN-1:0]   res;
    int                nb;
    sh = win >> {ofs, 3'b000};
    nb = 8 << len;
    case (len)
      2'b00:   sgn = sh[7];
      2'b01:   sgn = sh[15];
      2'b10:   sgn = sh[31];
      default: sgn = sh[63];
    endcase
    sgn = sgn & ~uns;
    for (int i = 0; i < XLEN; i++) begin
      res[i] = (i < nb) ? sh[i] : sgn;
    end
    return res;
  endfunction

  // Request decode: byte offset, boundary crossing and illegal length.
  always_comb begin
    req_ofs     = bus_io.req_addr[OFS_W-1:0];
    req_split   = (int'(req_ofs) + (1 << bus_io.req_len)) > BYTES;
    req_illegal = (XLEN == 32) && (bus_io.req_len == LEN_8B);
    req_trap    = TRAP_EN && req_split;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and handshake outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    mem_req_c   = 1'b0;
    rsp_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (bus_io.req_valid)
          state_d = (req_illegal || req_trap) ? ST_RESP : ST_RD0;
      end
      ST_RD0: begin
        mem_req_c = 1'b1;
        if (bus_io.mem_ack) state_d = split_q ? ST_RD1 : ST_RESP;
      end
      ST_RD1: begin
        mem_req_c = 1'b1;
        if (bus_io.mem_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_c = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, bus address sequencing, read capture and result formatting.
  // The result is formatted on the ack edge so it is already registered in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      ofs_q       <= '0;
      len_q       <= '0;
      uns_q       <= 1'b0;
      split_q     <= 1'b0;
      mem_addr_q  <= '0;
      lo_q        <= '0;
      rsp_data_q  <= '0;
      rsp_split_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_io.req_valid) begin
            ofs_q      <= req_ofs;
            len_q      <= bus_io.req_len;
            uns_q      <= bus_io.req_uns;
            split_q    <= req_split;
            mem_addr_q <= {bus_io.req_addr[AW-1:OFS_W], {OFS_W{1'b0}}};
            if (req_illegal) begin
              rsp_data_q  <= '0;
              rsp_split_q <= 1'b0;
              rsp_err_q   <= 1'b1;
            end else if (req_trap) begin
              rsp_data_q  <= '0;
              rsp_split_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        ST_RD0: begin
          if (bus_io.mem_ack) begin
            lo_q <= bus_io.mem_rdata;
            if (split_q) begin
              // Second word follows; the address wraps modulo 2^AW.
              mem_addr_q <= mem_addr_q + AW'(BYTES);
            end else begin
              rsp_data_q  <= fmt_load({{XLEN{1'b0}}, bus_io.mem_rdata}, ofs_q, len_q, uns_q);
              rsp_split_q <= 1'b0;
              rsp_err_q   <= 1'b0;
            end
          end
        end
        ST_RD1: begin
          if (bus_io.mem_ack) begin
            rsp_data_q  <= fmt_load({bus_io.mem_rdata, lo_q}, ofs_q, len_q, uns_q);
            rsp_split_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_io.req_ready = req_ready_c;
  assign bus_io.mem_req   = mem_req_c;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.rsp_valid = rsp_valid_c;
  assign bus_io.rsp_data  = rsp_data_q;
  assign bus_io.rsp_split = rsp_split_q;
  assign bus_io.rsp_err   = rsp_err_q;
endmodule
